// File: rtl/signmag_decoder.sv
// signmag_decoder: bit-serial two's-complement to sign-magnitude converter
module signmag_decoder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign,
  output logic [WIDTH-2:0] mag,
  output logic             ovf
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t         state, state_n;
  logic [WIDTH-1:0] sh, res, res_n;
  logic [CW-1:0]  cnt;
  logic           neg, carry, carry_n, bit_r, last;

  // One full-adder stage: negation adds the carry into the inverted LSB
  always_comb begin
    bit_r   = neg ? (~sh[0] ^ carry) : sh[0];
    carry_n = ~sh[0] & carry;
    res_n   = {bit_r, res[WIDTH-1:1]};
    last    = cnt == CW'(WIDTH - 1);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_n   = state;
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    case (state)
      IDLE:    state_n = in_valid ? CONV : IDLE;
      CONV:    state_n = last ? DONE : CONV;
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: load on accept, shift one bit per CONV cycle, publish result on the last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh    <= '0;
      res   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      carry <= 1'b0;
      sign  <= 1'b0;
      mag   <= '0;
      ovf   <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sh    <= A;
      neg   <= A[WIDTH-1];
      carry <= 1'b1;
      cnt   <= '0;
      res   <= '0;
    end else if (state == CONV) begin
      sh    <= sh >> 1;
      res   <= res_n;
      carry <= carry_n;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sign <= neg;
        mag  <= res_n[WIDTH-2:0];
        ovf  <= res_n[WIDTH-1];
      end
    end
  end
endmodule
